sprite_rom_arbiter: RTL
=======================

Name: sprite_rom_arbiter

Overview:
- Shares one synchronous sprite ROM port among several pixel renderers: dino, obstacle 1, obstacle 2 and background object.
- Uses round-robin arbitration with a registered grant and a one-hot response strobe.
- Sits between the render blocks' ROM-counter outputs and a single merged sprite ROM, so the per-sprite ROM instances collapse into one.
- Throughput is one access per clock. The longest wait for any requester is NUM_REQ-1 cycles after it becomes eligible.

Parameters:
- NUM_REQ, 4, number of requesters (index 0 = dino, 1 = obs1, 2 = obs2, 3 = bg).
- ADDR_W, 8, ROM counter/address width per requester.
- SEL_W, 3, sprite-select width (player state / obstacle type) per requester.
- DATA_W, 1, ROM data width (sprite colour bit).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_enable  in  1  when high, new grants are allowed; in-flight accesses always complete
- i_req  in  NUM_REQ  per-requester request level; held until the matching o_gnt bit is seen
- i_addr  in  NUM_REQ*ADDR_W  packed addresses, requester k at bits [k*ADDR_W +: ADDR_W]
- i_sel  in  NUM_REQ*SEL_W  packed sprite selects, same packing as i_addr
- o_gnt  out  NUM_REQ  one-hot grant, one-cycle pulse per grant
- o_rom_en  out  1  ROM read strobe
- o_rom_addr  out  ADDR_W  ROM address
- o_rom_sel  out  SEL_W  ROM sprite select
- i_rom_data  in  DATA_W  ROM read data, valid in the cycle after o_rom_en
- o_rsp_valid  out  NUM_REQ  one-hot response strobe
- o_rsp_data  out  DATA_W  response data, equal to i_rom_data
- o_busy  out  1  equals o_rom_en | (|o_rsp_valid)

Behaviour:
- Reset (async, rst=1): all of the following clear immediately:
  - o_gnt=0, o_rom_en=0, o_rom_addr=0, o_rom_sel=0
  - o_rsp_valid=0, internal response id=0
  - round-robin pointer ptr=0
  - an in-flight access is dropped; no o_rsp_valid follows reset release.
- Arbitration runs at every rising edge:
  - eligible = i_req & ~o_gnt. The requester granted this cycle is masked, so a held req is never double-granted.
  - If i_enable=1 and eligible≠0, the winner k is the first set bit of eligible, searching from index ptr upward with wrap modulo NUM_REQ.
  - On a win, the next cycle has:
    - o_gnt = 1<<k, o_rom_en=1
    - o_rom_addr = addr slice k, o_rom_sel = sel slice k (sampled at the arbitration edge)
    - ptr = (k+1) mod NUM_REQ.
  - With no winner, the next cycle has o_gnt=0 and o_rom_en=0; o_rom_addr and o_rom_sel hold their values; ptr holds.
- Latency:
  - req sampled at the edge ending cycle t → o_gnt/o_rom_en in cycle t+1 → o_rsp_valid[k]=1 in cycle t+2.
  - o_rsp_valid is o_gnt delayed one cycle (registered).
  - o_rsp_data = i_rom_data, combinational passthrough.
- Handshake:
  - The requester holds req, addr and sel stable until o_gnt[k]=1.
  - req still high in the cycle after the grant cycle counts as a new request.
  - A lone continuously-requesting master is granted every other cycle.
- Simultaneous events:
  - Multiple eligible requesters: round-robin order from ptr; ties never starve.
  - Grant and response overlap across different requesters: both are legal in the same cycle.
- i_enable falling while an access is in flight: the response still issues; no new o_gnt until i_enable=1.
- A req dropped before its grant is legal; it is simply not granted.
- Address and select values are passed through unchanged; there is no width arithmetic.
- Implementation is registered grant logic plus a priority-rotate; no combinational path from i_req to o_gnt.

Test Plan:
- Reset, then i_req=4'b0001 with addr0=8'h2A, sel0=3'd5, held until grant → o_gnt=0001, o_rom_en=1, o_rom_addr=2A, o_rom_sel=5 one cycle later. o_rsp_valid=0001 the following cycle, with o_rsp_data equal to driven i_rom_data.
- All four requesters assert in the same cycle after reset, each dropping on its own grant → o_gnt = 0001, 0010, 0100, 1000 in four consecutive cycles. o_rsp_valid shows the same sequence delayed by one cycle.
- Requester 1 held high continuously for 10 cycles, others idle → o_gnt[1] pulses every other cycle (5 grants); o_gnt is never high two cycles in a row.
- Requesters 0 and 2 held high continuously → o_gnt alternates 0001, 0100, 0001, 0100 on consecutive cycles; o_busy stays 1.
- i_enable=0 with i_req=1111 → no grants while low. Raise i_enable → first grant goes to the requester at the current ptr.
- Assert rst in the cycle o_rom_en=1 → all outputs 0 immediately, no o_rsp_valid after release, and ptr=0 (next simultaneous request grants index 0 first).

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite ROM port among the
// dino, obstacle and background renderers. Grants are registered, and the
// one-hot response strobe follows each grant by one cycle.
module sprite_rom_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned DATA_W  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_enable,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*SEL_W-1:0]  i_sel,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic                      o_rom_en,
  output logic [ADDR_W-1:0]         o_rom_addr,
  output logic [SEL_W-1:0]          o_rom_sel,
  input  logic [DATA_W-1:0]         i_rom_data,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_busy
);

  localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic               rom_en_q, rom_en_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [SEL_W-1:0]   rom_sel_q, rom_sel_d;
  logic [PtrW-1:0]    ptr_q, ptr_d;

  logic [NUM_REQ-1:0] eligible;
  logic               win;
  logic [PtrW-1:0]    win_idx;
  int unsigned        idx;

  // Rotating priority search: first eligible requester at or after ptr.
  // The requester granted this cycle is masked so a held req is not re-granted.
  always_comb begin
    eligible = i_req & ~gnt_q;
    win      = 1'b0;
    win_idx  = '0;
    idx      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(ptr_q) + i) % NUM_REQ;
      if (!win && eligible[idx]) begin
        win     = 1'b1;
        win_idx = PtrW'(idx);
      end
    end
  end

  // Next-state for grant, ROM command, pointer and response strobe.
  always_comb begin
    gnt_d       = '0;
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_sel_d   = rom_sel_q;
    ptr_d       = ptr_q;
    rsp_valid_d = gnt_q;
    if (i_enable && win) begin
      gnt_d      = NUM_REQ'(1) << win_idx;
      rom_en_d   = 1'b1;
      rom_addr_d = i_addr[win_idx*ADDR_W +: ADDR_W];
      rom_sel_d  = i_sel[win_idx*SEL_W +: SEL_W];
      ptr_d      = (win_idx == PtrW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // State registers; reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_q       <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_sel_q   <= '0;
      ptr_q       <= '0;
      rsp_valid_q <= '0;
    end else begin
      gnt_q       <= gnt_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      rom_sel_q   <= rom_sel_d;
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign o_gnt       = gnt_q;
  assign o_rom_en    = rom_en_q;
  assign o_rom_addr  = rom_addr_q;
  assign o_rom_sel   = rom_sel_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = i_rom_data;
  assign o_busy      = rom_en_q | (|rsp_valid_q);

endmodule
